// File: rtl/ssd1306_oled_driver.sv
// SSD1306 128x32 OLED driver: power sequencer plus a write-only 4-wire SPI
// byte engine. Power-up and power-down command bytes, as well as user
// command/data bytes, all go through the same byte engine.
module ssd1306_oled_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int SCLK_HALF  = 10,
  parameter int VDD_DELAY  = 100_000,
  parameter int RST_CYCLES = 400,
  parameter int VCC_DELAY  = 10_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  should_turn_power_on,
  input  logic                  should_send_din,
  input  logic                  is_din_data,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ssd1306_vdd,
  output logic                  ssd1306_vcc,
  output logic                  ssd1306_reset,
  output logic                  ssd1306_cs,
  output logic                  ssd1306_dc,
  output logic                  ssd1306_sdin,
  output logic                  ssd1306_sclk
);

  localparam logic [15:0] HALF_LAST = 16'(SCLK_HALF - 1);
  localparam logic [31:0] VDD_LAST  = 32'(VDD_DELAY - 1);
  localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] VCC_LAST  = 32'(VCC_DELAY - 1);
  // Engine steps (each SCLK_HALF long): 0 = setup with cs low and sclk high,
  // 1..2W = bit half-periods (odd: sclk low, even: sclk high),
  // 2W+1..2W+2 = mandatory cs-high gap before the engine is free again.
  localparam logic [5:0]  LAST_BIT  = 6'(2 * DATA_WIDTH);
  localparam logic [5:0]  LAST_GAP  = 6'(2 * DATA_WIDTH + 2);

  typedef enum logic [3:0] {
    S_OFF, S_VDD_WAIT, S_RST_LOW, S_RST_WAIT, S_INIT, S_VCC_WAIT,
    S_DISP_ON, S_READY, S_SEND, S_DSOFF, S_VCC_OFF_WAIT
  } state_t;

  state_t                state_reg, state_next;
  logic [31:0]           wait_cnt_reg;
  logic [2:0]            cmd_idx_reg;
  logic                  issued_reg, arm_reg;
  logic                  vdd_reg, vcc_reg, rstn_reg;
  logic                  vdd_next, vcc_next, rstn_next;
  logic                  eng_start, eng_dc, idx_inc, accept;
  logic [DATA_WIDTH-1:0] eng_byte, init_byte;

  logic                  eng_busy_reg, cs_reg, sclk_reg, sdin_reg, dc_reg;
  logic [15:0]           half_cnt_reg;
  logic [5:0]            step_reg;
  logic [DATA_WIDTH-1:0] shift_reg;

  // Init command table: display off, charge pump on, precharge period.
  always_comb begin
    init_byte = DATA_WIDTH'(8'hAE);
    case (cmd_idx_reg)
      3'd1:    init_byte = DATA_WIDTH'(8'h8D);
      3'd2:    init_byte = DATA_WIDTH'(8'h14);
      3'd3:    init_byte = DATA_WIDTH'(8'hD9);
      3'd4:    init_byte = DATA_WIDTH'(8'hF1);
      default: init_byte = DATA_WIDTH'(8'hAE);
    endcase
  end

  // Sequencer next-state and supply/engine control.
  always_comb begin
    state_next = state_reg;
    vdd_next   = vdd_reg;
    vcc_next   = vcc_reg;
    rstn_next  = rstn_reg;
    eng_start  = 1'b0;
    eng_byte   = din;
    eng_dc     = is_din_data;
    idx_inc    = 1'b0;
    accept     = 1'b0;
    if (state_reg inside {S_VDD_WAIT, S_RST_LOW, S_RST_WAIT, S_INIT, S_VCC_WAIT, S_DISP_ON}
        && !should_turn_power_on && !eng_busy_reg) begin
      // Power-off mid power-up: once no byte is in flight, drop straight to
      // OFF if the panel supply never came on, otherwise shut down properly.
      if (vcc_reg) begin
        vdd_next   = 1'b1;
        rstn_next  = 1'b1;
        state_next = S_OFF;
      end else begin
        state_next = S_DSOFF;
      end
    end else begin
      case (state_reg)
        S_OFF: if (should_turn_power_on) begin
          vdd_next   = 1'b0;
          state_next = S_VDD_WAIT;
        end
        S_VDD_WAIT: if (wait_cnt_reg == VDD_LAST) begin
          rstn_next  = 1'b0;
          state_next = S_RST_LOW;
        end
        S_RST_LOW: if (wait_cnt_reg == RST_LAST) begin
          rstn_next  = 1'b1;
          state_next = S_RST_WAIT;
        end
        S_RST_WAIT: if (wait_cnt_reg == RST_LAST) state_next = S_INIT;
        S_INIT: if (!eng_busy_reg) begin
          if (!issued_reg) begin
            eng_start = 1'b1;
            eng_byte  = init_byte;
            eng_dc    = 1'b0;
          end else if (cmd_idx_reg == 3'd4) begin
            vcc_next   = 1'b0;
            state_next = S_VCC_WAIT;
          end else begin
            idx_inc = 1'b1;
          end
        end
        S_VCC_WAIT: if (wait_cnt_reg == VCC_LAST) state_next = S_DISP_ON;
        S_DISP_ON: if (!eng_busy_reg) begin
          if (!issued_reg) begin
            eng_start = 1'b1;
            eng_byte  = DATA_WIDTH'(8'hAF);
            eng_dc    = 1'b0;
          end else begin
            state_next = S_READY;
          end
        end
        S_READY: if (!eng_busy_reg) begin
          // Power-off wins over a simultaneous send request.
          if (!should_turn_power_on) begin
            state_next = S_DSOFF;
          end else if (should_send_din && arm_reg) begin
            eng_start  = 1'b1;
            accept     = 1'b1;
            state_next = S_SEND;
          end
        end
        S_SEND: if (!eng_busy_reg) state_next = S_READY;
        S_DSOFF: if (!eng_busy_reg) begin
          if (!issued_reg) begin
            eng_start = 1'b1;
            eng_byte  = DATA_WIDTH'(8'hAE);
            eng_dc    = 1'b0;
          end else begin
            vcc_next   = 1'b1;
            state_next = S_VCC_OFF_WAIT;
          end
        end
        S_VCC_OFF_WAIT: if (wait_cnt_reg == VCC_LAST) begin
          vdd_next   = 1'b1;
          state_next = S_OFF;
        end
        default: state_next = S_OFF;
      endcase
    end
  end

  // Sequencer state, delay counter, command index, supplies and arm flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_OFF;
      wait_cnt_reg <= '0;
      cmd_idx_reg  <= '0;
      issued_reg   <= 1'b0;
      arm_reg      <= 1'b0;
      vdd_reg      <= 1'b1;
      vcc_reg      <= 1'b1;
      rstn_reg     <= 1'b1;
    end else begin
      state_reg <= state_next;
      vdd_reg   <= vdd_next;
      vcc_reg   <= vcc_next;
      rstn_reg  <= rstn_next;
      if (state_next != state_reg) begin
        wait_cnt_reg <= '0;
        cmd_idx_reg  <= '0;
      end else begin
        wait_cnt_reg <= wait_cnt_reg + 32'd1;
        if (idx_inc) cmd_idx_reg <= cmd_idx_reg + 3'd1;
      end
      if (eng_start) issued_reg <= 1'b1;
      else if (state_next != state_reg || idx_inc) issued_reg <= 1'b0;
      // A held-high request re-arms only after it has been seen low.
      if (!should_send_din) arm_reg <= 1'b1;
      else if (accept) arm_reg <= 1'b0;
    end
  end

  // SPI byte engine: setup half-period, MSB-first bits, then cs-high gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_busy_reg <= 1'b0;
      cs_reg       <= 1'b1;
      sclk_reg     <= 1'b1;
      sdin_reg     <= 1'b0;
      dc_reg       <= 1'b0;
      half_cnt_reg <= '0;
      step_reg     <= '0;
      shift_reg    <= '0;
    end else if (eng_start) begin
      eng_busy_reg <= 1'b1;
      shift_reg    <= eng_byte;
      dc_reg       <= eng_dc;
      cs_reg       <= 1'b0;
      sclk_reg     <= 1'b1;
      half_cnt_reg <= '0;
      step_reg     <= '0;
    end else if (eng_busy_reg) begin
      if (half_cnt_reg != HALF_LAST) begin
        half_cnt_reg <= half_cnt_reg + 16'd1;
      end else begin
        half_cnt_reg <= '0;
        step_reg     <= step_reg + 6'd1;
        if (step_reg < LAST_BIT) begin
          if (!step_reg[0]) begin
            // Falling edge: present the next bit while sclk is low.
            sclk_reg  <= 1'b0;
            sdin_reg  <= shift_reg[DATA_WIDTH-1];
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          end else begin
            sclk_reg <= 1'b1;
          end
        end else if (step_reg == LAST_BIT) begin
          cs_reg <= 1'b1;
        end else if (step_reg == LAST_GAP) begin
          eng_busy_reg <= 1'b0;
        end
      end
    end
  end

  assign ssd1306_vdd   = vdd_reg;
  assign ssd1306_vcc   = vcc_reg;
  assign ssd1306_reset = rstn_reg;
  assign ssd1306_cs    = cs_reg;
  assign ssd1306_dc    = dc_reg;
  assign ssd1306_sdin  = sdin_reg;
  assign ssd1306_sclk  = sclk_reg;

endmodule

// File: tb/tb_ssd1306_oled_driver.sv
// Bench for ssd1306_oled_driver: an SPI monitor decodes every cs-low frame
// into {dc, byte, bit count, length}, and each scenario task compares the
// decoded frames and supply/reset pin timing against the panel's expected
// power sequence and byte protocol.
module tb_ssd1306_oled_driver;
  localparam int H    = 3;
  localparam int VDDD = 40;
  localparam int RSTC = 6;
  localparam int VCCD = 80;
  localparam int FLEN = 17 * H;

  logic clk = 1'b0;
  logic reset, should_turn_power_on, should_send_din, is_din_data;
  logic [7:0] din;
  logic ssd1306_vdd, ssd1306_vcc, ssd1306_reset, ssd1306_cs;
  logic ssd1306_dc, ssd1306_sdin, ssd1306_sclk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] b;
    logic       dc;
    int         nbits;
    int         len;
    bit         dc_bad;
  } frame_t;
  frame_t frames[$];

  // Monitor state.
  bit         in_frame = 1'b0;
  int         cur_len, cur_bits;
  logic [7:0] cur_b;
  logic       cur_dc;
  bit         cur_dc_bad;
  logic       prev_cs = 1'b1, prev_sclk = 1'b1, prev_sdin = 1'b0;
  int         gap_cnt = 100000, min_gap = 100000;
  int         sclk_falls = 0, sdin_bad = 0;

  ssd1306_oled_driver #(
    .DATA_WIDTH(8), .SCLK_HALF(H), .VDD_DELAY(VDDD),
    .RST_CYCLES(RSTC), .VCC_DELAY(VCCD)
  ) dut (
    .clk(clk), .reset(reset),
    .should_turn_power_on(should_turn_power_on),
    .should_send_din(should_send_din), .is_din_data(is_din_data), .din(din),
    .ssd1306_vdd(ssd1306_vdd), .ssd1306_vcc(ssd1306_vcc),
    .ssd1306_reset(ssd1306_reset), .ssd1306_cs(ssd1306_cs),
    .ssd1306_dc(ssd1306_dc), .ssd1306_sdin(ssd1306_sdin),
    .ssd1306_sclk(ssd1306_sclk)
  );

  always #5 clk = ~clk;

  // SPI decoder, sampling on the falling clk edge.
  always @(negedge clk) begin
    if (reset) begin
      in_frame  = 1'b0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b1;
      prev_sdin = ssd1306_sdin;
      gap_cnt   = 100000;
    end else begin
      if (!ssd1306_sclk && prev_sclk) sclk_falls++;
      if (prev_cs && !ssd1306_cs) begin
        in_frame = 1'b1; cur_len = 0; cur_bits = 0; cur_b = 8'h00;
        cur_dc = ssd1306_dc; cur_dc_bad = 1'b0;
        if (gap_cnt < min_gap) min_gap = gap_cnt;
      end
      if (!ssd1306_cs && in_frame) begin
        cur_len++;
        if (ssd1306_dc !== cur_dc) cur_dc_bad = 1'b1;
        if (ssd1306_sclk && !prev_sclk) begin
          cur_b = {cur_b[6:0], ssd1306_sdin};
          cur_bits++;
        end
        if (ssd1306_sclk && ssd1306_sdin !== prev_sdin) sdin_bad++;
      end
      if (!prev_cs && ssd1306_cs && in_frame) begin
        frames.push_back('{b: cur_b, dc: cur_dc, nbits: cur_bits, len: cur_len, dc_bad: cur_dc_bad});
        in_frame = 1'b0;
        gap_cnt  = 0;
      end
      if (ssd1306_cs) gap_cnt++;
      prev_cs   = ssd1306_cs;
      prev_sclk = ssd1306_sclk;
      prev_sdin = ssd1306_sdin;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int falls0;
    reset = 1'b1; should_turn_power_on = 1'b0; should_send_din = 1'b0;
    is_din_data = 1'b0; din = 8'h00;
    cyc_wait(3);
    reset = 1'b0;
    falls0 = sclk_falls;
    cyc_wait(100);
    vectors++;
    if ({ssd1306_vdd, ssd1306_vcc, ssd1306_reset, ssd1306_cs, ssd1306_sclk, ssd1306_dc, ssd1306_sdin} !== 7'b1111100) begin
      miscompares++;
      $display("FAIL reset_pins: got vdd,vcc,rst,cs,sclk,dc,sdin=%b, expected 1111100",
               {ssd1306_vdd, ssd1306_vcc, ssd1306_reset, ssd1306_cs, ssd1306_sclk, ssd1306_dc, ssd1306_sdin});
    end
    vectors++;
    if (sclk_falls != falls0 || frames.size() != 0) begin
      miscompares++;
      $display("FAIL reset_idle: got %0d sclk falls %0d frames, expected 0 and 0", sclk_falls - falls0, frames.size());
    end
    $display("reset: idle pins checked");
  endtask

  task automatic test_power_up();
    int k;
    frame_t f;
    logic [7:0] init_seq [5];
    init_seq = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1};
    should_turn_power_on = 1'b1;
    k = 0;
    while (ssd1306_vdd && k < 5) begin cyc_wait(1); k++; end
    vectors++;
    if (ssd1306_vdd !== 1'b0 || k > 2) begin
      miscompares++;
      $display("FAIL vdd_on: got vdd=%b after %0d cycles, expected vdd=0 within 2", ssd1306_vdd, k);
    end
    k = 0;
    while (ssd1306_reset && k < VDDD + 50) begin cyc_wait(1); k++; end
    vectors++;
    if (ssd1306_reset !== 1'b0 || k != VDDD) begin
      miscompares++;
      $display("FAIL vdd_to_reset: got reset=%b after %0d cycles, expected 0 after %0d", ssd1306_reset, k, VDDD);
    end
    k = 0;
    while (!ssd1306_reset && k < RSTC + 50) begin cyc_wait(1); k++; end
    vectors++;
    if (ssd1306_reset !== 1'b1 || k != RSTC) begin
      miscompares++;
      $display("FAIL reset_width: got %0d cycles low, expected %0d", k, RSTC);
    end
    for (int j = 0; j < 2000 && frames.size() < 5; j++) cyc_wait(1);
    vectors++;
    if (frames.size() != 5 || ssd1306_vcc !== 1'b1) begin
      miscompares++;
      $display("FAIL init_frames: got %0d frames vcc=%b, expected 5 frames vcc=1", frames.size(), ssd1306_vcc);
    end
    for (int i = 0; i < 5 && frames.size() > 0; i++) begin
      f = frames.pop_front();
      $display("init frame %0d: dc=%0d byte=%02h bits=%0d len=%0d", i, f.dc, f.b, f.nbits, f.len);
      vectors++;
      if (f.dc !== 1'b0 || f.b !== init_seq[i] || f.nbits != 8 || f.len != FLEN || f.dc_bad) begin
        miscompares++;
        $display("FAIL init_frame%0d: got dc=%b byte=%02h bits=%0d len=%0d dcvar=%0d, expected dc=0 byte=%02h bits=8 len=%0d dcvar=0",
                 i, f.dc, f.b, f.nbits, f.len, f.dc_bad, init_seq[i], FLEN);
      end
    end
    k = 0;
    while (ssd1306_vcc && k < 200) begin cyc_wait(1); k++; end
    vectors++;
    if (ssd1306_vcc !== 1'b0 || frames.size() != 0) begin
      miscompares++;
      $display("FAIL vcc_on: got vcc=%b with %0d extra frames, expected vcc=0 and 0", ssd1306_vcc, frames.size());
    end
    k = 0;
    while (ssd1306_cs && k < VCCD + 200) begin cyc_wait(1); k++; end
    vectors++;
    if (k < VCCD) begin
      miscompares++;
      $display("FAIL vcc_wait: got %0d cycles before display-on frame, expected at least %0d", k, VCCD);
    end
    for (int j = 0; j < 200 && frames.size() < 1; j++) cyc_wait(1);
    vectors++;
    if (frames.size() != 1) begin
      miscompares++;
      $display("FAIL disp_on_count: got %0d frames, expected 1", frames.size());
    end else begin
      f = frames.pop_front();
      $display("display-on frame: dc=%0d byte=%02h", f.dc, f.b);
      vectors++;
      if (f.dc !== 1'b0 || f.b !== 8'hAF || f.len != FLEN) begin
        miscompares++;
        $display("FAIL disp_on: got dc=%b byte=%02h len=%0d, expected dc=0 byte=af len=%0d", f.dc, f.b, f.len, FLEN);
      end
    end
  endtask

  task automatic test_cmd_hold();
    int k;
    frame_t f;
    cyc_wait(10);
    is_din_data = 1'b0; din = 8'hA5; should_send_din = 1'b1;
    k = 0;
    while (ssd1306_cs && k < 10) begin cyc_wait(1); k++; end
    vectors++;
    if (ssd1306_cs !== 1'b0 || k < 1 || k > 2) begin
      miscompares++;
      $display("FAIL send_latency: got cs=%b after %0d cycles, expected cs=0 in 1..2", ssd1306_cs, k);
    end
    k = 0;
    while (!ssd1306_cs && k < FLEN + 20) begin cyc_wait(1); k++; end
    cyc_wait(3 * FLEN);
    should_send_din = 1'b0;
    cyc_wait(10);
    vectors++;
    if (frames.size() != 1) begin
      miscompares++;
      $display("FAIL hold_one_frame: got %0d frames, expected 1", frames.size());
    end
    if (frames.size() > 0) begin
      f = frames.pop_front();
      $display("held request frame: dc=%0d byte=%02h", f.dc, f.b);
      vectors++;
      if (f.dc !== 1'b0 || f.b !== 8'hA5 || f.nbits != 8 || f.len != FLEN || f.dc_bad) begin
        miscompares++;
        $display("FAIL hold_frame: got dc=%b byte=%02h bits=%0d len=%0d, expected dc=0 byte=a5 bits=8 len=%0d",
                 f.dc, f.b, f.nbits, f.len, FLEN);
      end
    end
    frames.delete();
  endtask

  task automatic test_random_bytes();
    logic [7:0] eb;
    logic       ed;
    frame_t     f;
    for (int n = 0; n < 8; n++) begin
      eb = 8'($urandom_range(0, 255));
      ed = 1'($urandom_range(0, 1));
      din = eb; is_din_data = ed; should_send_din = 1'b1;
      for (int k = 0; k < 20 && ssd1306_cs; k++) cyc_wait(1);
      should_send_din = 1'b0;
      din = 8'($urandom_range(0, 255)); is_din_data = 1'($urandom_range(0, 1));
      for (int k = 0; k < FLEN + 40 && frames.size() < 1; k++) cyc_wait(1);
      cyc_wait(2 * H + 3);
      vectors++;
      if (frames.size() != 1) begin
        miscompares++;
        $display("FAIL rand_count%0d: got %0d frames, expected 1", n, frames.size());
        frames.delete();
      end else begin
        f = frames.pop_front();
        $display("random frame %0d: dc=%0d byte=%02h (expected dc=%0d byte=%02h)", n, f.dc, f.b, ed, eb);
        vectors++;
        if (f.dc !== ed || f.b !== eb || f.nbits != 8 || f.len != FLEN || f.dc_bad) begin
          miscompares++;
          $display("FAIL rand_frame%0d: got dc=%b byte=%02h bits=%0d len=%0d, expected dc=%b byte=%02h bits=8 len=%0d",
                   n, f.dc, f.b, f.nbits, f.len, ed, eb, FLEN);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t f;
    logic [7:0] second;
    second = 8'($urandom_range(0, 255));
    min_gap = 100000;
    is_din_data = 1'b1; din = 8'h3C; should_send_din = 1'b1;
    for (int k = 0; k < 20 && ssd1306_cs; k++) cyc_wait(1);
    should_send_din = 1'b0;
    cyc_wait(2);
    din = second; should_send_din = 1'b1;
    for (int k = 0; k < FLEN + 40 && frames.size() < 1; k++) cyc_wait(1);
    for (int k = 0; k < 40 && ssd1306_cs; k++) cyc_wait(1);
    should_send_din = 1'b0;
    for (int k = 0; k < FLEN + 40 && frames.size() < 2; k++) cyc_wait(1);
    cyc_wait(2 * H + 3);
    vectors++;
    if (frames.size() != 2 || min_gap < 2 * H) begin
      miscompares++;
      $display("FAIL b2b: got %0d frames min gap %0d, expected 2 frames gap >= %0d", frames.size(), min_gap, 2 * H);
    end
    if (frames.size() == 2) begin
      f = frames.pop_front();
      vectors++;
      if (f.dc !== 1'b1 || f.b !== 8'h3C) begin
        miscompares++;
        $display("FAIL b2b_first: got dc=%b byte=%02h, expected dc=1 byte=3c", f.dc, f.b);
      end
      f = frames.pop_front();
      $display("back-to-back frames: 3c then %02h, gap %0d", f.b, min_gap);
      vectors++;
      if (f.dc !== 1'b1 || f.b !== second) begin
        miscompares++;
        $display("FAIL b2b_second: got dc=%b byte=%02h, expected dc=1 byte=%02h", f.dc, f.b, second);
      end
    end
    frames.delete();
  endtask

  task automatic test_power_down();
    int k, falls0;
    frame_t f;
    should_turn_power_on = 1'b0;
    for (int j = 0; j < FLEN + 40 && frames.size() < 1; j++) cyc_wait(1);
    vectors++;
    if (frames.size() != 1) begin
      miscompares++;
      $display("FAIL dsoff_count: got %0d frames, expected 1", frames.size());
    end else begin
      f = frames.pop_front();
      $display("power-down frame: dc=%0d byte=%02h", f.dc, f.b);
      vectors++;
      if (f.dc !== 1'b0 || f.b !== 8'hAE) begin
        miscompares++;
        $display("FAIL dsoff: got dc=%b byte=%02h, expected dc=0 byte=ae", f.dc, f.b);
      end
    end
    for (int j = 0; j < 50 && !ssd1306_vcc; j++) cyc_wait(1);
    k = 0;
    while (!ssd1306_vdd && k < VCCD + 50) begin cyc_wait(1); k++; end
    vectors++;
    if (ssd1306_vcc !== 1'b1 || ssd1306_vdd !== 1'b1 || k < VCCD || k > VCCD + 2) begin
      miscompares++;
      $display("FAIL vcc_to_vdd: got vcc=%b vdd=%b after %0d cycles, expected both 1 after %0d",
               ssd1306_vcc, ssd1306_vdd, k, VCCD);
    end
    falls0 = sclk_falls;
    cyc_wait(50);
    vectors++;
    if (sclk_falls != falls0 || ssd1306_vdd !== 1'b1 || ssd1306_cs !== 1'b1) begin
      miscompares++;
      $display("FAIL off_idle: got %0d sclk falls vdd=%b cs=%b, expected 0 falls vdd=1 cs=1",
               sclk_falls - falls0, ssd1306_vdd, ssd1306_cs);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    frame_t f;
    should_turn_power_on = 1'b1;
    for (int j = 0; j < 3000 && frames.size() < 6; j++) cyc_wait(1);
    vectors++;
    if (frames.size() != 6) begin
      miscompares++;
      $display("FAIL repower_frames: got %0d frames, expected 6", frames.size());
    end
    frames.delete();
    cyc_wait(10);
    din = 8'($urandom_range(0, 255)); is_din_data = 1'b1; should_send_din = 1'b1;
    for (int j = 0; j < 20 && ssd1306_cs; j++) cyc_wait(1);
    should_send_din = 1'b0;
    cyc_wait(5);
    vectors++;
    if (ssd1306_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_setup: got cs=%b, expected 0", ssd1306_cs);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({ssd1306_cs, ssd1306_sclk, ssd1306_vdd, ssd1306_vcc, ssd1306_reset} !== 5'b11111) begin
      miscompares++;
      $display("FAIL async_reset: got cs,sclk,vdd,vcc,rst=%b, expected 11111",
               {ssd1306_cs, ssd1306_sclk, ssd1306_vdd, ssd1306_vcc, ssd1306_reset});
    end
    cyc_wait(3);
    frames.delete();
    reset = 1'b0;
    k = 0;
    while (ssd1306_vdd && k < 5) begin cyc_wait(1); k++; end
    vectors++;
    if (ssd1306_vdd !== 1'b0 || k > 2) begin
      miscompares++;
      $display("FAIL restart_vdd: got vdd=%b after %0d cycles, expected 0 within 2", ssd1306_vdd, k);
    end
    for (int j = 0; j < 1000 && frames.size() < 1; j++) cyc_wait(1);
    vectors++;
    if (frames.size() < 1) begin
      miscompares++;
      $display("FAIL restart_frame: got no frame, expected ae");
    end else begin
      f = frames.pop_front();
      $display("restart first frame: dc=%0d byte=%02h", f.dc, f.b);
      vectors++;
      if (f.b !== 8'hAE || f.dc !== 1'b0) begin
        miscompares++;
        $display("FAIL restart_ae: got dc=%b byte=%02h, expected dc=0 byte=ae", f.dc, f.b);
      end
    end
    vectors++;
    if (sdin_bad != 0) begin
      miscompares++;
      $display("FAIL sdin_stable: got %0d sdin changes while sclk high, expected 0", sdin_bad);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_cmd_hold();
    test_random_bytes();
    test_back_to_back();
    test_power_down();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
